// File: rtl/pc_fetch_unit.sv
// Stage-1 program counter and instruction-fetch sequencer: one i-cache request per PC,
// response handed to stage 2 directly or via a one-entry hold buffer under stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_next_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic        drop, drop_d;
  logic        valid_d;
  logic [31:0] inst_data, inst_data_d;
  logic [31:0] inst_pc_d;

  // PCs are word aligned, so the two low bits of both PC sources are dropped.
  logic [31:0] next_aligned;
  logic [31:0] flush_aligned;
  logic        unused_low_bits;

  assign next_aligned    = {pc_next_in[31:2], 2'b00};
  assign flush_aligned   = {flush_pc[31:2], 2'b00};
  assign unused_low_bits = ^{pc_next_in[1:0], flush_pc[1:0]};

  assign pc_4             = pc + 32'd4;
  assign icache_addr      = pc;
  assign icache_req_valid = (state == S_REQ);
  assign inst_out         = inst_valid ? inst_data : NOP_INST;

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves one
    // unassigned; without this, synthesis infers a latch.
    state_d     = state;
    pc_d        = pc;
    drop_d      = drop;
    valid_d     = 1'b0;
    inst_data_d = inst_data;
    inst_pc_d   = inst_pc;

    unique case (state)
      S_BOOT: begin
        if (flush) pc_d = flush_aligned;
        state_d = S_REQ;
      end

      S_REQ: begin
        if (flush) begin
          pc_d = flush_aligned;
          // A request accepted in the flush cycle still returns data; mark it for discard.
          if (icache_req_ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (icache_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (icache_resp_valid) begin
          if (flush || drop) begin
            if (flush) pc_d = flush_aligned;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall) begin
            valid_d     = 1'b1;
            inst_data_d = icache_resp_data;
            inst_pc_d   = pc;
            pc_d        = next_aligned;
            state_d     = S_REQ;
          end else begin
            // The data register doubles as the hold buffer; pc advances only on delivery.
            valid_d     = 1'b1;
            inst_data_d = icache_resp_data;
            inst_pc_d   = pc;
            state_d     = S_HOLD;
          end
        end else if (flush) begin
          pc_d   = flush_aligned;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (flush) begin
          pc_d    = flush_aligned;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d = 1'b1;
          pc_d    = next_aligned;
          state_d = S_REQ;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= NOP_INST;
      inst_pc    <= RESET_PC;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drop       <= drop_d;
      inst_valid <= valid_d;
      inst_data  <= inst_data_d;
      inst_pc    <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change and outputs are checked on the
// falling clock edge, expected values are hand-computed constants.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_next_in;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_next_in        (pc_next_in),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_addr       (icache_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .pc                (pc),
    .pc_4              (pc_4),
    .inst_valid        (inst_valid),
    .inst_out          (inst_out),
    .inst_pc           (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts and ends at a falling edge with the DUT in REQ and the request ready low.
  task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] next, input logic [31:0] exp_pc);
    check({tag, "_req_valid"}, {31'd0, icache_req_valid}, 32'd1);
    check({tag, "_addr"}, icache_addr, addr);
    icache_req_ready = 1'b1;
    pc_next_in       = next;
    step();
    icache_req_ready = 1'b0;
    check({tag, "_wait_req_valid"}, {31'd0, icache_req_valid}, 32'd0);
    check({tag, "_wait_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = data;
    step();
    icache_resp_valid = 1'b0;
    check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_inst_out"}, inst_out, data);
    check({tag, "_inst_pc"}, inst_pc, addr);
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    reset_n           = 1'b0;
    pc_next_in        = 32'd0;
    stall             = 1'b0;
    flush             = 1'b0;
    flush_pc          = 32'd0;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_data  = 32'd0;

    // Reset values
    step();
    check("rst_pc", pc, 32'h0000_2000);
    check("rst_pc_4", pc_4, 32'h0000_2004);
    check("rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_out", inst_out, NOP);
    check("rst_inst_pc", inst_pc, 32'h0000_2000);

    // BOOT then REQ; ready held low for 4 cycles keeps the request stable
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rdy_low_req_valid", {31'd0, icache_req_valid}, 32'd1);
      check("rdy_low_addr", icache_addr, 32'h0000_2000);
      check("rdy_low_inst_valid", {31'd0, inst_valid}, 32'd0);
      if (i < 3) step();
    end

    // Sequential fetch with pc_next_in = pc + 4
    fetch_one("seq0", 32'h0000_2000, 32'h1111_0001, 32'h0000_2004, 32'h0000_2004);
    fetch_one("seq1", 32'h0000_2004, 32'h1111_0002, 32'h0000_2008, 32'h0000_2008);
    fetch_one("seq2", 32'h0000_2008, 32'h1111_0003, 32'h0000_200C, 32'h0000_200C);

    // Response under stall goes to HOLD for 3 cycles
    icache_req_ready = 1'b1;
    pc_next_in       = 32'h0000_2010;
    step();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'h0050_0093;
    stall             = 1'b1;
    step();
    icache_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst_out", inst_out, 32'h0050_0093);
      check("hold_inst_pc", inst_pc, 32'h0000_200C);
      check("hold_pc", pc, 32'h0000_200C);
      check("hold_req_valid", {31'd0, icache_req_valid}, 32'd0);
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    check("release_pc", pc, 32'h0000_2010);
    check("release_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("release_inst_out", inst_out, 32'h0050_0093);
    check("release_req_valid", {31'd0, icache_req_valid}, 32'd1);
    step();
    check("after_release_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("after_release_inst_out", inst_out, NOP);

    // Flush during WAIT, response the following cycle is dropped
    icache_req_ready = 1'b1;
    pc_next_in       = 32'h0000_2014;
    step();
    icache_req_ready = 1'b0;
    flush            = 1'b1;
    flush_pc         = 32'h0000_3000;
    step();
    flush = 1'b0;
    check("flush_wait_pc", pc, 32'h0000_3000);
    check("flush_wait_req_valid", {31'd0, icache_req_valid}, 32'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_BEEF;
    step();
    icache_resp_valid = 1'b0;
    check("flush_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_drop_inst_out", inst_out, NOP);
    check("flush_drop_req_valid", {31'd0, icache_req_valid}, 32'd1);
    check("flush_drop_addr", icache_addr, 32'h0000_3000);

    // Flush in REQ while the cache accepts: request treated as outstanding and dropped
    flush            = 1'b1;
    flush_pc         = 32'h0000_3103;
    icache_req_ready = 1'b1;
    step();
    flush            = 1'b0;
    icache_req_ready = 1'b0;
    check("flush_req_pc", pc, 32'h0000_3100);
    check("flush_req_req_valid", {31'd0, icache_req_valid}, 32'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hCAFE_0000;
    step();
    icache_resp_valid = 1'b0;
    check("flush_req_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_req_addr", icache_addr, 32'h0000_3100);

    // PC wrap and low-bit masking of pc_next_in
    fetch_one("wrap0", 32'h0000_3100, 32'h2222_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    check("wrap_pc_4", pc_4, 32'h0000_0000);
    fetch_one("wrap1", 32'hFFFF_FFFC, 32'h2222_0002, 32'h0000_1003, 32'h0000_1000);

    // Asynchronous reset during WAIT; late response after release is ignored
    icache_req_ready = 1'b1;
    pc_next_in       = 32'h0000_1004;
    step();
    icache_req_ready = 1'b0;
    check("pre_rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0000_2000);
    check("async_rst_inst_pc", inst_pc, 32'h0000_2000);
    check("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("async_rst_inst_out", inst_out, NOP);
    check("async_rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    step();
    reset_n           = 1'b1;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'h0BAD_0BAD;
    step();
    icache_resp_valid = 1'b0;
    check("restart_inst_valid", {31'd0, inst_valid}, 32'd0);
    fetch_one("restart", 32'h0000_2000, 32'h3333_0001, 32'h0000_2004, 32'h0000_2004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
